// File: rtl/victory_chain_stage_pkg.sv
// rtl/victory_chain_stage_pkg.sv - shared state type and winner-id field widths
package victory_chain_stage_pkg;

   typedef enum logic {SEARCH = 1'b0, FOUND = 1'b1} victory_state_t;

   localparam int SPURIOUS_BITS = 8;

   // A single-lane processor still carries a 1-bit lane field so decoders stay uniform
   function automatic int lane_bits(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

   function automatic int win_bits(input int partition_bits, input int lanes, input int nonce_bits);
      return partition_bits + lane_bits(lanes) + nonce_bits;
   endfunction

endpackage

// File: rtl/victory_chain_stage_tag_pipe.sv
// rtl/victory_chain_stage_tag_pipe.sv - valid/nonce tag shift register with synchronous flush
module victory_tag_pipe #(
   parameter int DEPTH     = 4,
   parameter int NONCEBITS = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 in_valid,
   input  logic [NONCEBITS-1:0] in_nonce,
   output logic                 out_valid,
   output logic [NONCEBITS-1:0] out_nonce
);

   logic [DEPTH-1:0]                valid_q, valid_d;
   logic [DEPTH-1:0][NONCEBITS-1:0] nonce_q, nonce_d;

   // Stage 0 always takes the new item: work issued alongside a flush belongs to the new block
   always_comb begin
      valid_d    = valid_q;
      nonce_d    = nonce_q;
      valid_d[0] = in_valid;
      nonce_d[0] = in_nonce;
      for (int k = 1; k < DEPTH; k++) begin
         valid_d[k] = valid_q[k-1] & ~flush;
         nonce_d[k] = nonce_q[k-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         nonce_q <= '0;
      end else begin
         valid_q <= valid_d;
         nonce_q <= nonce_d;
      end
   end

   assign out_valid = valid_q[DEPTH-1];
   assign out_nonce = nonce_q[DEPTH-1];

endmodule

// File: rtl/victory_chain_stage.sv
// rtl/victory_chain_stage.sv - per-processor win capture and chain merge for LANES hash lanes
module victory_chain_stage
   import victory_chain_stage_pkg::*;
#(
   parameter int LANES           = 4,
   parameter int LATENCY         = 4,
   parameter int PARTITIONBITS   = 2,
   parameter int PROCESSORNUMBER = 0,
   parameter int NONCEBITS       = 8,
   parameter int WINBITS         = win_bits(PARTITIONBITS, LANES, NONCEBITS)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_i,
   input  logic                     newblock_i,
   input  logic [NONCEBITS-1:0]     nonce_i,
   input  logic [LANES-1:0]         lane_success_i,
   input  logic                     victory_i,
   input  logic [WINBITS-1:0]       winner_i,
   output logic                     valid_o,
   output logic                     newblock_o,
   output logic                     victory_o,
   output logic [WINBITS-1:0]       winner_o,
   output logic [SPURIOUS_BITS-1:0] spurious_o
);

   localparam int LANEBITS = lane_bits(LANES);

   logic                 tag_valid;
   logic [NONCEBITS-1:0] tag_nonce;
   logic                 hit;
   logic [LANEBITS-1:0]  lane_idx;

   victory_state_t            state_q, state_d;
   logic [WINBITS-1:0]        local_win_q, local_win_d;
   logic [SPURIOUS_BITS-1:0]  spurious_q, spurious_d;
   logic                      victory_q, victory_d;
   logic [WINBITS-1:0]        winner_q, winner_d;
   logic                      valid_q, valid_d;
   logic                      newblock_q, newblock_d;

   victory_tag_pipe #(
      .DEPTH     (LATENCY),
      .NONCEBITS (NONCEBITS)
   ) u_tag_pipe (
      .clk       (clk),
      .rst       (rst),
      .flush     (newblock_i),
      .in_valid  (valid_i),
      .in_nonce  (nonce_i),
      .out_valid (tag_valid),
      .out_nonce (tag_nonce)
   );

   assign hit = |lane_success_i;

   // Descending scan so the lowest set lane is the last assignment
   always_comb begin
      lane_idx = '0;
      for (int i = LANES - 1; i >= 0; i--) begin
         if (lane_success_i[i]) lane_idx = LANEBITS'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      local_win_d = local_win_q;
      spurious_d  = spurious_q;
      if (newblock_i) begin
         state_d     = SEARCH;
         local_win_d = '0;
      end else if (state_q == SEARCH && tag_valid && hit) begin
         state_d     = FOUND;
         local_win_d = {PARTITIONBITS'(PROCESSORNUMBER), lane_idx, tag_nonce};
      end
      if (hit && !tag_valid && spurious_q != '1) spurious_d = spurious_q + 1'b1;

      // Upstream processors outrank the local win
      victory_d  = victory_i | (state_q == FOUND);
      winner_d   = victory_i ? winner_i : ((state_q == FOUND) ? local_win_q : '0);
      valid_d    = valid_i;
      newblock_d = newblock_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= SEARCH;
         local_win_q <= '0;
         spurious_q  <= '0;
         victory_q   <= 1'b0;
         winner_q    <= '0;
         valid_q     <= 1'b0;
         newblock_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         local_win_q <= local_win_d;
         spurious_q  <= spurious_d;
         victory_q   <= victory_d;
         winner_q    <= winner_d;
         valid_q     <= valid_d;
         newblock_q  <= newblock_d;
      end
   end

   assign valid_o    = valid_q;
   assign newblock_o = newblock_q;
   assign victory_o  = victory_q;
   assign winner_o   = winner_q;
   assign spurious_o = spurious_q;

endmodule

// File: tb/tb_victory_chain_stage.sv
// tb/tb_victory_chain_stage.sv - randomized and directed bench with a cycle-history reference model
module tb_victory_chain_stage;

   localparam int L    = 4;
   localparam int HMAX = 8192;

   logic        clk = 1'b0;
   logic        rst, valid_i, newblock_i, victory_i;
   logic [7:0]  nonce_i;
   logic [3:0]  lane_success_i;
   logic [11:0] winner_i;
   logic        valid_o, newblock_o, victory_o;
   logic [11:0] winner_o;
   logic [7:0]  spurious_o;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   bit         hv [HMAX];
   bit         hn [HMAX];
   bit         hr [HMAX];
   logic [7:0] hnc[HMAX];

   bit          m_found, m_vo, m_vld, m_nbo;
   logic [11:0] m_win, m_wo;
   int          m_spur;

   always #5 clk = ~clk;

   victory_chain_stage #(
      .LANES(4), .LATENCY(L), .PARTITIONBITS(2), .PROCESSORNUMBER(2), .NONCEBITS(8)
   ) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .newblock_i(newblock_i), .nonce_i(nonce_i),
      .lane_success_i(lane_success_i), .victory_i(victory_i), .winner_i(winner_i),
      .valid_o(valid_o), .newblock_o(newblock_o), .victory_o(victory_o),
      .winner_o(winner_o), .spurious_o(spurious_o)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // An item issued at cycle s reaches the validators at s+L unless a reset hit it
   // while in flight (including its issue cycle) or a new block arrived strictly after issue.
   function automatic bit aligned(input int t, output logic [7:0] n);
      int s;
      n = '0;
      if (t < L) return 0;
      s = t - L;
      if (!hv[s]) return 0;
      for (int c = s; c < t; c++) if (hr[c]) return 0;
      for (int c = s + 1; c < t; c++) if (hn[c]) return 0;
      n = hnc[s];
      return 1;
   endfunction

   function automatic logic [1:0] lowest(input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) return 2'(i);
      return 2'd0;
   endfunction

   task automatic step(input bit v, input bit nb, input logic [7:0] n, input logic [3:0] s,
                       input bit vi, input logic [11:0] wi, input bit r);
      logic [7:0] an;
      bit         av;
      bit         old_found;
      logic [11:0] old_win;
      valid_i = v; newblock_i = nb; nonce_i = n; lane_success_i = s;
      victory_i = vi; winner_i = wi; rst = r;
      @(posedge clk);
      hv[cyc] = v; hn[cyc] = nb; hnc[cyc] = n; hr[cyc] = r;
      if (r) begin
         m_found = 0; m_win = '0; m_spur = 0; m_vo = 0; m_wo = '0; m_vld = 0; m_nbo = 0;
      end else begin
         av = aligned(cyc, an);
         old_found = m_found;
         old_win = m_win;
         m_vo = vi || old_found;
         m_wo = vi ? wi : (old_found ? old_win : 12'h0);
         if (nb) begin
            m_found = 0; m_win = '0;
         end else if (!old_found && av && s != 0) begin
            m_found = 1; m_win = {2'd2, lowest(s), an};
         end
         if (s != 0 && !av && m_spur < 255) m_spur++;
         m_vld = v; m_nbo = nb;
      end
      cyc++;
      #1;
      chk("victory_o", 32'(victory_o), 32'(m_vo));
      chk("winner_o", 32'(winner_o), 32'(m_wo));
      chk("spurious_o", 32'(spurious_o), 32'(m_spur));
      chk("valid_o", 32'(valid_o), 32'(m_vld));
      chk("newblock_o", 32'(newblock_o), 32'(m_nbo));
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) step(0, 0, 8'h00, 4'b0000, 0, 12'h0, 0);
   endtask

   initial begin
      step(0, 0, 8'h00, 4'b0000, 0, 12'h0, 1);
      step(0, 0, 8'h00, 4'b0000, 0, 12'h0, 1);
      chk("reset_victory", 32'(victory_o), 32'd0);
      chk("reset_spurious", 32'(spurious_o), 32'd0);

      // single hit on lane 2
      step(1, 0, 8'h35, 4'b0000, 0, 12'h0, 0);
      idle(3);
      step(0, 0, 8'h00, 4'b0100, 0, 12'h0, 0);
      idle(1);
      chk("single_hit_victory", 32'(victory_o), 32'd1);
      chk("single_hit_winner", 32'(winner_o), 32'hA35);
      idle(3);
      chk("single_hit_hold", 32'(winner_o), 32'hA35);

      // upstream priority and revert
      step(0, 0, 8'h00, 4'b0000, 1, 12'h0A7, 0);
      chk("upstream_winner", 32'(winner_o), 32'h0A7);
      step(0, 0, 8'h00, 4'b0000, 0, 12'h000, 0);
      chk("upstream_revert", 32'(winner_o), 32'hA35);

      // multi-lane hit, lowest lane wins, later hit ignored
      step(0, 1, 8'h00, 4'b0000, 0, 12'h0, 0);
      idle(1);
      step(1, 0, 8'h10, 4'b0000, 0, 12'h0, 0);
      idle(3);
      step(0, 0, 8'h00, 4'b1010, 0, 12'h0, 0);
      idle(1);
      chk("multi_lane_winner", 32'(winner_o), 32'h910);
      step(1, 0, 8'h44, 4'b0000, 0, 12'h0, 0);
      idle(3);
      step(0, 0, 8'h00, 4'b0001, 0, 12'h0, 0);
      idle(1);
      chk("found_ignores_hit", 32'(winner_o), 32'h910);

      // newblock flushes an in-flight item
      step(0, 1, 8'h00, 4'b0000, 0, 12'h0, 0);
      idle(4);
      step(1, 0, 8'h20, 4'b0000, 0, 12'h0, 0);
      idle(1);
      step(0, 1, 8'h00, 4'b0000, 0, 12'h0, 0);
      chk("newblock_o_pulse", 32'(newblock_o), 32'd1);
      idle(1);
      step(0, 0, 8'h00, 4'b0001, 0, 12'h0, 0);
      chk("flush_spurious", 32'(spurious_o), 32'd1);
      idle(2);
      chk("flush_no_victory", 32'(victory_o), 32'd0);

      // newblock with a same-cycle success while FOUND
      step(1, 0, 8'h55, 4'b0000, 0, 12'h0, 0);
      idle(3);
      step(0, 0, 8'h00, 4'b0001, 0, 12'h0, 0);
      idle(1);
      chk("found_again", 32'(victory_o), 32'd1);
      step(1, 0, 8'h56, 4'b0000, 0, 12'h0, 0);
      idle(3);
      step(0, 1, 8'h00, 4'b0010, 0, 12'h0, 0);
      idle(1);
      chk("nb_clears_victory", 32'(victory_o), 32'd0);
      chk("nb_clears_winner", 32'(winner_o), 32'd0);

      // reset with tags in flight, then saturation
      step(1, 0, 8'h66, 4'b0000, 0, 12'h0, 0);
      idle(3);
      step(1, 0, 8'h01, 4'b0001, 0, 12'h0, 0);
      step(1, 0, 8'h02, 4'b0000, 0, 12'h0, 0);
      step(1, 0, 8'h03, 4'b0000, 0, 12'h0, 0);
      step(0, 0, 8'h00, 4'b0000, 0, 12'h0, 1);
      chk("mid_reset_victory", 32'(victory_o), 32'd0);
      for (int i = 0; i < 4; i++) step(0, 0, 8'h00, 4'b1111, 0, 12'h0, 0);
      chk("post_reset_spurious", 32'(spurious_o), 32'd4);
      chk("post_reset_victory", 32'(victory_o), 32'd0);
      for (int i = 0; i < 300; i++) step(0, 0, 8'h00, 4'b0001, 0, 12'h0, 0);
      chk("spurious_saturate", 32'(spurious_o), 32'd255);

      step(0, 0, 8'h00, 4'b0000, 0, 12'h0, 1);
      for (int i = 0; i < 1500; i++) begin
         step(($urandom_range(0, 1) == 1),
              ($urandom_range(0, 39) == 0),
              8'($urandom),
              ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'b0000,
              ($urandom_range(0, 9) == 0),
              12'($urandom),
              ($urandom_range(0, 199) == 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
